// File: rtl/rom_loader_pkg.sv
// Shared types and helpers for the ROM download router.
package rom_loader_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_e;

   localparam int unsigned LANE_MAX = 4;
   localparam int unsigned LANE_W   = $clog2(LANE_MAX);
   localparam int unsigned DATA_W   = 32;

   // Pull field idx of width w out of a packed per-region parameter vector.
   function automatic logic [31:0] reg_field(input logic [511:0] vec,
                                             input int unsigned idx,
                                             input int unsigned w);
      logic [511:0] sh;
      sh = vec >> (idx * w);
      return sh[31:0] & ((32'd1 << w) - 32'd1);
   endfunction

endpackage

// File: rtl/rom_loader_dec.sv
// Combinational region decoder: first (lowest-index) matching region, lane and word offset.
module rom_loader_dec
   import rom_loader_pkg::*;
#(
   parameter int unsigned        NREG       = 8,
   parameter int unsigned        AW         = 25,
   parameter logic [NREG*AW-1:0] REG_BASE   = '0,
   parameter logic [NREG*5-1:0]  REG_SZLOG2 = '0,
   parameter logic [NREG*3-1:0]  REG_BYTES  = '0
) (
   input  logic [AW-1:0]     addr_i,
   output logic              hit_o,
   output logic [3:0]        idx_o,
   output logic [LANE_W-1:0] lane_o,
   output logic              last_o,
   output logic [AW-1:0]     offset_o
);

   logic [AW-1:0]     f_base;
   logic [4:0]        f_szl;
   logic [2:0]        f_bytes;
   logic [AW-1:0]     low;
   logic [LANE_W-1:0] lmask;
   logic [1:0]        lg;

   always_comb begin
      hit_o    = 1'b0;
      idx_o    = '0;
      lane_o   = '0;
      last_o   = 1'b0;
      offset_o = '0;
      f_base   = '0;
      f_szl    = '0;
      f_bytes  = '0;
      low      = '0;
      lmask    = '0;
      lg       = '0;
      for (int unsigned r = 0; r < NREG; r++) begin
         f_base  = AW'(reg_field(512'(REG_BASE), r, AW));
         f_szl   = 5'(reg_field(512'(REG_SZLOG2), r, 5));
         f_bytes = 3'(reg_field(512'(REG_BYTES), r, 3));
         low     = AW'((32'd1 << f_szl) - 32'd1);
         case (f_bytes)
            3'd4:    begin lmask = 2'b11; lg = 2'd2; end
            3'd2:    begin lmask = 2'b01; lg = 2'd1; end
            default: begin lmask = 2'b00; lg = 2'd0; end
         endcase
         if (!hit_o && (((addr_i ^ f_base) & ~low) == '0)) begin
            hit_o    = 1'b1;
            idx_o    = 4'(r);
            lane_o   = addr_i[LANE_W-1:0] & lmask;
            last_o   = ((addr_i[LANE_W-1:0] & lmask) == lmask);
            offset_o = (addr_i & low) >> lg;
         end
      end
   end

endmodule

// File: rtl/rom_loader.sv
// Routes the ioctl ROM byte stream into per-region word writes and holds the core in reset.
// Define ROM_LOADER_CKSUM_EN to build the running byte checksum on O_CKSUM.
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter int unsigned        NREG       = 8,
   parameter int unsigned        AW         = 25,
   parameter logic [7:0]         ROM_INDEX  = 8'h00,
   parameter logic [NREG*AW-1:0] REG_BASE   = '0,
   parameter logic [NREG*5-1:0]  REG_SZLOG2 = '0,
   parameter logic [NREG*3-1:0]  REG_BYTES  = '0,
   parameter logic [NREG-1:0]    REG_SWAP   = '0,
   parameter int unsigned        HOLD_CYC   = 16
) (
   input  logic              I_CLK,
   input  logic              I_RESET,
   input  logic              I_DL,
   input  logic              I_WR,
   input  logic [7:0]        I_INDEX,
   input  logic [AW-1:0]     I_ADDR,
   input  logic [7:0]        I_DATA,
   output logic [NREG-1:0]   O_WE,
   output logic [AW-1:0]     O_ADDR,
   output logic [DATA_W-1:0] O_DATA,
   output logic              O_BUSY,
   output logic              O_DONE,
   output logic              O_ERR,
   output logic [15:0]       O_CKSUM
);

   logic              dec_hit;
   logic [3:0]        dec_idx;
   logic [LANE_W-1:0] dec_lane;
   logic              dec_last;
   logic [AW-1:0]     dec_offset;

   rom_loader_dec #(
      .NREG       (NREG),
      .AW         (AW),
      .REG_BASE   (REG_BASE),
      .REG_SZLOG2 (REG_SZLOG2),
      .REG_BYTES  (REG_BYTES)
   ) u_dec (
      .addr_i   (I_ADDR),
      .hit_o    (dec_hit),
      .idx_o    (dec_idx),
      .lane_o   (dec_lane),
      .last_o   (dec_last),
      .offset_o (dec_offset)
   );

   state_e            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [NREG-1:0]   we_q, we_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              dl_q;
   logic              first_q, first_d;
   logic [AW-1:0]     prev_q, prev_d;

   logic              accept, dl_rise, first_byte, swap;
   logic [NREG-1:0]   onehot;
   logic [DATA_W-1:0] acc_base, word;

   always_comb begin
      accept     = I_WR && I_DL && (I_INDEX == ROM_INDEX);
      dl_rise    = I_DL && !dl_q;
      first_byte = first_q || dl_rise;

      for (int unsigned r = 0; r < NREG; r++) begin
         onehot[r] = (dec_idx == 4'(r));
      end
      swap = |(onehot & REG_SWAP);

      // Lane 0 starts a fresh word so no stale bytes leak into it.
      acc_base = (dec_lane == '0) ? '0 : acc_q;
      if (swap) begin
         word = acc_base | (DATA_W'(I_DATA) << {dec_lane, 3'b000});
      end else begin
         word = {acc_base[DATA_W-9:0], I_DATA};
      end

      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: if (accept) state_d = LOAD;
         LOAD: begin
            if (!I_DL) begin
               state_d = HOLD;
               cnt_d   = '0;
            end
         end
         HOLD: begin
            if (I_DL) begin
               state_d = LOAD;
            end else if (cnt_q == 8'(HOLD_CYC - 1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      acc_d  = acc_q;
      we_d   = '0;
      addr_d = addr_q;
      data_d = data_q;
      if (accept && dec_hit) begin
         acc_d = word;
         if (dec_last) begin
            we_d   = onehot;
            addr_d = dec_offset;
            data_d = word;
         end
      end

      err_d = err_q;
      if (dl_rise) err_d = 1'b0;
      if (accept && dec_hit && !first_byte && (dec_lane != '0) &&
          (I_ADDR != prev_q + AW'(1))) begin
         err_d = 1'b1;
      end

      first_d = first_q;
      if (dl_rise) first_d = 1'b1;
      if (accept)  first_d = 1'b0;
      prev_d = accept ? I_ADDR : prev_q;
   end

   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         we_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         dl_q    <= 1'b0;
         first_q <= 1'b1;
         prev_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         done_q  <= done_d;
         err_q   <= err_d;
         dl_q    <= I_DL;
         first_q <= first_d;
         prev_q  <= prev_d;
      end
   end

`ifdef ROM_LOADER_CKSUM_EN
   logic [15:0] cksum_q, cksum_d;

   always_comb begin
      cksum_d = cksum_q;
      if (accept) begin
         cksum_d = (state_q == IDLE) ? 16'(I_DATA) : cksum_q + 16'(I_DATA);
      end
   end

   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) cksum_q <= '0;
      else         cksum_q <= cksum_d;
   end

   assign O_CKSUM = cksum_q;
`else
   assign O_CKSUM = '0;
`endif

   assign O_WE   = we_q;
   assign O_ADDR = addr_q;
   assign O_DATA = data_q;
   assign O_BUSY = (state_q != IDLE);
   assign O_DONE = done_q;
   assign O_ERR  = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: behavioural model plus directed literal checks.
module tb_rom_loader;

   localparam int unsigned NREG = 8;
   localparam int unsigned AW   = 25;
   localparam int unsigned HOLD = 16;

   localparam logic [NREG*AW-1:0] P_BASE = {25'h1007000, 25'h1006000, 25'h1005000, 25'h0000000,
                                            25'h0070000, 25'h0068000, 25'h0040000, 25'h0000000};
   localparam logic [NREG*5-1:0]  P_SZ   = {5'd12, 5'd12, 5'd12, 5'd20, 5'd12, 5'd12, 5'd15, 5'd18};
   localparam logic [NREG*3-1:0]  P_BY   = {3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd1, 3'd2, 3'd4};
   localparam logic [NREG-1:0]    P_SW   = 8'b0000_0010;

`ifdef ROM_LOADER_CKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   // Region table seen by the model, index 0..7.
   int unsigned m_base[8] = '{32'h0, 32'h40000, 32'h68000, 32'h70000, 32'h0,
                              32'h1005000, 32'h1006000, 32'h1007000};
   int unsigned m_szl[8]  = '{18, 15, 12, 12, 20, 12, 12, 12};
   int unsigned m_nb[8]   = '{4, 2, 1, 2, 1, 1, 1, 1};
   bit          m_sw[8]   = '{0, 1, 0, 0, 0, 0, 0, 0};

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            dl = 1'b0;
   logic            wr = 1'b0;
   logic [7:0]      index_v = 8'h00;
   logic [AW-1:0]   addr = '0;
   logic [7:0]      data = 8'h00;
   logic [NREG-1:0] we;
   logic [AW-1:0]   o_addr;
   logic [31:0]     o_data;
   logic            busy, done, err;
   logic [15:0]     cksum;

   rom_loader #(
      .NREG       (NREG),
      .AW         (AW),
      .ROM_INDEX  (8'h00),
      .REG_BASE   (P_BASE),
      .REG_SZLOG2 (P_SZ),
      .REG_BYTES  (P_BY),
      .REG_SWAP   (P_SW),
      .HOLD_CYC   (HOLD)
   ) dut (
      .I_CLK   (clk),
      .I_RESET (rst),
      .I_DL    (dl),
      .I_WR    (wr),
      .I_INDEX (index_v),
      .I_ADDR  (addr),
      .I_DATA  (data),
      .O_WE    (we),
      .O_ADDR  (o_addr),
      .O_DATA  (o_data),
      .O_BUSY  (busy),
      .O_DONE  (done),
      .O_ERR   (err),
      .O_CKSUM (cksum)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [NREG-1:0] exp_we;
   logic [31:0]     exp_addr, exp_data;
   bit              exp_done, exp_err;
   bit              m_busy, m_loading, m_first, m_dl_prev;
   int              m_hold_left;
   int unsigned     m_cksum, m_prev;
   logic [7:0]      m_q[$];
   logic [7:0]      m_lanes[4];

   task automatic model_reset();
      exp_we = '0; exp_addr = '0; exp_data = '0; exp_done = 0; exp_err = 0;
      m_busy = 0; m_loading = 0; m_first = 1; m_dl_prev = 0; m_hold_left = 0;
      m_cksum = 0; m_prev = 0; m_q.delete();
      for (int i = 0; i < 4; i++) m_lanes[i] = 8'h00;
   endtask

   task automatic model_step();
      bit          acc;
      int          hit;
      int unsigned a, lane;
      logic [31:0] w;
      a = 32'(addr);
      exp_we = '0;
      exp_done = 0;
      acc = dl && wr && (index_v == 8'h00);
      if (dl && !m_dl_prev) begin
         m_first = 1;
         exp_err = 0;
      end
      hit = -1;
      for (int r = 0; r < 8; r++)
         if (hit < 0 && (a >> m_szl[r]) == (m_base[r] >> m_szl[r])) hit = r;

      if (!m_busy) begin
         if (acc) begin m_busy = 1; m_loading = 1; m_cksum = 0; end
      end else if (m_loading) begin
         if (!dl) begin m_loading = 0; m_hold_left = HOLD; end
      end else if (dl) begin
         m_loading = 1;
      end else begin
         m_hold_left--;
         if (m_hold_left == 0) begin m_busy = 0; exp_done = 1; end
      end

      if (acc) begin
         m_cksum = (m_cksum + 32'(data)) % 65536;
         if (hit >= 0) begin
            lane = (a - m_base[hit]) % m_nb[hit];
            if (!m_first && lane != 0 && a != m_prev + 1) exp_err = 1;
            if (lane == 0) begin
               m_q.delete();
               for (int i = 0; i < 4; i++) m_lanes[i] = 8'h00;
            end
            m_q.push_back(data);
            m_lanes[lane] = data;
            if (lane == m_nb[hit] - 1) begin
               w = 0;
               if (m_sw[hit]) begin
                  for (int i = 0; i < 4; i++) w = w | (32'(m_lanes[i]) << (8 * i));
               end else begin
                  foreach (m_q[i]) w = (w << 8) | 32'(m_q[i]);
               end
               exp_we   = NREG'(1) << hit;
               exp_addr = (a - m_base[hit]) / m_nb[hit];
               exp_data = w;
            end
         end
         m_first = 0;
         m_prev  = a;
      end
      m_dl_prev = dl;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else     model_step();
      end
   end

   // Compare process: every falling edge once checking is enabled.
   initial begin
      wait (chk_en);
      forever begin
         @(negedge clk);
         check("we", 32'(we), 32'(exp_we));
         if (exp_we != '0) begin
            check("addr", 32'(o_addr), exp_addr);
            check("data", o_data, exp_data);
         end
         check("busy", 32'(busy), 32'(m_busy));
         check("done", 32'(done), 32'(exp_done));
         check("err", 32'(err), 32'(exp_err));
         check("cksum", 32'(cksum), CK ? m_cksum : 32'h0);
      end
   end

   // ---------------- directed stimulus ----------------
   // Called at posedge+1; returns at posedge+1 after the byte has been captured.
   task automatic put(input logic [AW-1:0] a, input logic [7:0] d, input logic [7:0] ix);
      wr = 1'b1; addr = a; data = d; index_v = ix;
      @(posedge clk); #1;
      wr = 1'b0; index_v = 8'h00;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!done && n < 40);
      check(name, 32'(n), 32'(HOLD + 1));
      check({name, "_busy"}, 32'(busy), 32'h0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_we", 32'(we), 32'h0);
      check("rst_addr", 32'(o_addr), 32'h0);
      check("rst_data", o_data, 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_cksum", 32'(cksum), 32'h0);
      rst = 1'b0;
      chk_en = 1'b1;
      @(posedge clk); #1;

      dl = 1'b1;
      put(25'h68010, 8'h5A, 8'h01);
      check("wrong_index_busy", 32'(busy), 32'h0);
      check("wrong_index_we", 32'(we), 32'h0);

      put(25'h00000, 8'hAA, 8'h00);
      check("first_busy", 32'(busy), 32'h1);
      put(25'h00001, 8'hBB, 8'h00);
      put(25'h00002, 8'hCC, 8'h00);
      put(25'h00003, 8'hDD, 8'h00);
      check("r0_we", 32'(we), 32'h01);
      check("r0_addr", 32'(o_addr), 32'h0);
      check("r0_data", o_data, 32'hAABBCCDD);

      put(25'h40002, 8'h12, 8'h00);
      put(25'h40003, 8'h34, 8'h00);
      check("r1_we", 32'(we), 32'h02);
      check("r1_addr", 32'(o_addr), 32'h1);
      check("r1_data", o_data, 32'h00003412);

      put(25'h68010, 8'h5A, 8'h00);
      check("r2_we", 32'(we), 32'h04);
      check("r2_addr", 32'(o_addr), 32'h10);
      check("r2_data", o_data, 32'h0000005A);

      put(25'h70004, 8'h77, 8'h00);
      put(25'h70005, 8'h88, 8'h00);
      check("r3_data", o_data, 32'h00007788);
      check("r3_addr", 32'(o_addr), 32'h2);

      put(25'h80005, 8'h66, 8'h00);
      check("r4_we", 32'(we), 32'h10);
      check("r4_addr", 32'(o_addr), 32'h80005);
      put(25'h00020, 8'h99, 8'h00);
      check("overlap_lowest_wins", 32'(we), 32'h0);
      put(25'hC00000, 8'h55, 8'h00);
      check("unmapped_we", 32'(we), 32'h0);
      check("no_err_yet", 32'(err), 32'h0);

      dl = 1'b0;
      wait_done("hold1");

      dl = 1'b1;
      put(25'h00000, 8'h01, 8'h00);
      put(25'h00001, 8'h02, 8'h00);
      put(25'h00002, 8'h03, 8'h00);
      put(25'h00003, 8'h04, 8'h00);
      check("ck_word", o_data, 32'h01020304);
      dl = 1'b0;
      wait_done("hold_cyc");
      check("cksum_lit", 32'(cksum), CK ? 32'h000A : 32'h0);

      dl = 1'b1;
      put(25'h00000, 8'hAA, 8'h00);
      put(25'h00001, 8'hBB, 8'h00);
      check("seq_ok_err", 32'(err), 32'h0);
      put(25'h00003, 8'hDD, 8'h00);
      check("gap_err", 32'(err), 32'h1);
      check("gap_data", o_data, 32'h00AABBDD);
      dl = 1'b0;
      wait_done("err_hold");
      check("err_sticky", 32'(err), 32'h1);
      dl = 1'b1;
      @(posedge clk); #1;
      check("err_clear", 32'(err), 32'h0);

      put(25'h68000, 8'h11, 8'h00);
      dl = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("hold_busy", 32'(busy), 32'h1);
      dl = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("reenter_busy", 32'(busy), 32'h1);
      check("reenter_nodone", 32'(done), 32'h0);
      put(25'h68001, 8'h22, 8'h00);
      check("reenter_data", o_data, 32'h00000022);
      dl = 1'b0;
      wait_done("reenter_hold");

      dl = 1'b1;
      put(25'h00000, 8'hAA, 8'h00);
      put(25'h00001, 8'hBB, 8'h00);
      rst = 1'b1;
      #1;
      check("abort_we", 32'(we), 32'h0);
      check("abort_addr", 32'(o_addr), 32'h0);
      check("abort_data", o_data, 32'h0);
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_done", 32'(done), 32'h0);
      check("abort_cksum", 32'(cksum), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      put(25'h00000, 8'h11, 8'h00);
      put(25'h00001, 8'h22, 8'h00);
      put(25'h00002, 8'h33, 8'h00);
      put(25'h00003, 8'h44, 8'h00);
      check("clean_we", 32'(we), 32'h01);
      check("clean_data", o_data, 32'h11223344);
      dl = 1'b0;
      wait_done("final_hold");

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
